rf_port_arbiter: RTL and testbench

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

---
 rtl/rf_pkg.sv | 31 +++
 rtl/rf_port_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rf_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the RF RAM port arbiter:
//   arb_mode_e     arbitration mode encodings (round-robin / fixed priority)
//   port_idx_w()   width of a port index for a given port count
//   arb_state_t    debug view of the arbiter's ownership/pointer state
// ---------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,   // rotating priority, pointer-based search
        ARB_FIXED = 1'b1    // lowest index always wins
    } arb_mode_e;

    localparam int MAX_PORTS = 8;
    localparam int MAX_IDX_W = 3;

    // Port index width; never below 1 so single-bit indices stay legal.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    // Fixed-width state snapshot so the debug port shape does not depend
    // on NUM_PORTS.
    typedef struct packed {
        logic                 owner_valid;
        logic [MAX_IDX_W-1:0] owner;
        logic [MAX_IDX_W-1:0] ptr;
    } arb_state_t;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_port_arbiter_if
// Port-side bundle between the requesting RF RAM clients and the arbiter.
//   req/lock/we   per-port request, hold-ownership and write enable
//   addr/wdata    per-port address and write data, port i at slice i
//   gnt           one-hot grant; an access is accepted when req[i] & gnt[i]
//   rvalid/rdata  per-port read-return strobe and shared read data
// Handshake: an access on port i completes in the cycle where req[i] and
// gnt[i] are both high; the port must hold its command until then.
// ---------------------------------------------------------------------------
interface rf_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 1408
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        lock;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority search.
//   req  request vector
//   ptr  index where the search starts; wraps past NUM_PORTS-1 to 0
//   gnt  one-hot grant of the first requester found, 0 when req = 0
// Driving ptr = 0 turns this into a fixed lowest-index-wins arbiter.
// ---------------------------------------------------------------------------
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int IDX_W    = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    logic             found;
    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] sel;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        sel   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // One extra bit so ptr + k cannot overflow before the wrap.
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_PORTS)) begin
                pos = pos - (IDX_W+1)'(NUM_PORTS);
            end
            sel = pos[IDX_W-1:0];
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// ---------------------------------------------------------------------------
// rf_port_arbiter
// Shares one RF RAM between NUM_PORTS clients.
//   clk, rst     clock and asynchronous active-high reset
//   bus          client bundle (rf_port_arbiter_if.slave)
//   ram_addr/ram_data/ram_we/ram_re   RAM command from the granted port
//   ram_q        RAM read data, RD_LAT cycles after ram_re
//   dbg_state    owner / pointer snapshot
// A locked access makes its port the owner; only the owner is granted until
// it completes an access with lock = 0. Reads are tagged with the port index
// in a RD_LAT-deep pipeline and returned on rvalid/rdata.
// ---------------------------------------------------------------------------
module rf_port_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 1408,
    parameter int RD_LAT    = 1,
    parameter int ARB_MODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    rf_port_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_data,
    output logic               ram_we,
    output logic               ram_re,
    input  logic [DATA_W-1:0]  ram_q,
    output arb_state_t         dbg_state
);

    localparam int   IDX_W = port_idx_w(NUM_PORTS);
    localparam logic FIXED = (ARB_MODE == int'(ARB_FIXED));

    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic                 owner_valid;
    logic [IDX_W-1:0]     search_ptr;
    logic [NUM_PORTS-1:0] search_gnt;
    logic [NUM_PORTS-1:0] gnt;
    logic [IDX_W-1:0]     g_idx;
    logic                 g_we;
    logic                 accepted;
    logic [NUM_PORTS-1:0] rvalid;

    logic                 ret_valid [RD_LAT];
    logic [IDX_W-1:0]     ret_idx   [RD_LAT];

    assign search_ptr = FIXED ? '0 : ptr;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .req (bus.req),
        .ptr (search_ptr),
        .gnt (search_gnt)
    );

    // An owner blocks everyone else, even while it is not requesting.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (owner_valid) begin
                gnt[owner] = bus.req[owner];
            end else begin
                gnt = search_gnt;
            end
        end
    end

    assign accepted = |gnt;

    // Route the granted port's command to the RAM.
    always_comb begin
        g_idx    = '0;
        g_we     = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                g_idx    = IDX_W'(i);
                g_we     = bus.we[i];
                ram_addr = bus.addr[i*ADDR_W +: ADDR_W];
                ram_data = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ram_we  = accepted & g_we;
    assign ram_re  = accepted & ~g_we;
    assign bus.gnt = gnt;

    // Ownership and pointer. The pointer stays put during a locked burst and
    // moves past the granted port on any unlocked access, including the one
    // that releases ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
        end else if (accepted) begin
            if (bus.lock[g_idx]) begin
                owner_valid <= 1'b1;
                owner       <= g_idx;
            end else begin
                owner_valid <= 1'b0;
                ptr         <= (g_idx == IDX_W'(NUM_PORTS-1)) ? '0 : g_idx + 1'b1;
            end
        end
    end

    // Read-return tag pipeline: stage RD_LAT-1 lines up with ram_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ret_valid[i] <= 1'b0;
                ret_idx[i]   <= '0;
            end
        end else begin
            ret_valid[0] <= ram_re;
            ret_idx[0]   <= g_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                ret_valid[i] <= ret_valid[i-1];
                ret_idx[i]   <= ret_idx[i-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (ret_valid[RD_LAT-1]) begin
            rvalid[ret_idx[RD_LAT-1]] = 1'b1;
        end
    end

    assign bus.rvalid = rvalid;
    assign bus.rdata  = ram_q;

    assign dbg_state.owner_valid = owner_valid;
    assign dbg_state.owner       = MAX_IDX_W'(owner);
    assign dbg_state.ptr         = MAX_IDX_W'(ptr);

endmodule

// File: tb/tb_rf_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_port_arbiter
// Instance A: round-robin, RD_LAT = 3, with a behavioural RAM and a
// reference model of grants and read returns. Instance B: fixed priority.
// ---------------------------------------------------------------------------
module tb_rf_port_arbiter;
    import rf_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int DW  = 64;
    localparam int LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    rf_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic          ram_we_a, ram_re_a, ram_we_b, ram_re_b;
    arb_state_t    dbg_a, dbg_b;

    rf_port_arbiter #(
        .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .ARB_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .ram_addr(ram_addr_a), .ram_data(ram_data_a),
        .ram_we(ram_we_a), .ram_re(ram_re_a), .ram_q(ram_q_a),
        .dbg_state(dbg_a)
    );

    rf_port_arbiter #(
        .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ARB_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b),
        .ram_we(ram_we_b), .ram_re(ram_re_b), .ram_q(ram_q_b),
        .dbg_state(dbg_b)
    );

    assign ram_q_b = '0;

    // Behavioural RF RAM for instance A: read data captured at the command
    // edge, delivered LAT cycles later.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        rd_pipe[0] <= ram_mem[ram_addr_a];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_q_a = rd_pipe[LAT-1];

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          exp_q[$];
    logic [DW-1:0] m_mem [16];
    int            m_ptr;
    bit            m_own_v;
    int            m_own;
    int            cyc;
    int            n_cmp;
    int            n_err;
    logic [N-1:0]  last_gnt, last_gnt_b;
    logic          last_we, last_re;

    task automatic check_val(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Grant rule: owner only; else first requester scanning from pointer.
    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
        int p;
        if (m_own_v) return r[m_own] ? (N'(1) << m_own) : '0;
        for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (r[p]) return N'(1) << p;
        end
        return '0;
    endfunction

    function automatic logic [N*AW-1:0] rand_addr();
        logic [N*AW-1:0] v;
        for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'($urandom_range(0, 15));
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_wdata();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = {$urandom(), $urandom()};
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle on instance A: inputs already driven; check at negedge,
    // update model, advance to posedge + 1.
    task automatic step_a();
        logic [N-1:0]  eg, erv;
        logic [DW-1:0] erd;
        logic [AW-1:0] ga;
        int            g;
        @(negedge clk);
        eg = model_gnt(bus_a.req);
        check_val("gnt", DW'(bus_a.gnt), DW'(eg));
        last_gnt = bus_a.gnt;
        last_we  = ram_we_a;
        last_re  = ram_re_a;
        erv = '0;
        erd = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i].due == cyc) begin
                erv[exp_q[i].port] = 1'b1;
                erd = exp_q[i].data;
            end
        end
        check_val("rvalid", DW'(bus_a.rvalid), DW'(erv));
        if (erv != '0) check_val("rdata", bus_a.rdata, erd);
        if (eg != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (eg[i]) g = i;
            ga = bus_a.addr[g*AW +: AW];
            check_val("ram_addr", DW'(ram_addr_a), DW'(ga));
            check_val("ram_we", DW'(ram_we_a), DW'(bus_a.we[g]));
            check_val("ram_re", DW'(ram_re_a), DW'(!bus_a.we[g]));
            if (bus_a.we[g]) begin
                check_val("ram_data", ram_data_a, bus_a.wdata[g*DW +: DW]);
                m_mem[ga] = bus_a.wdata[g*DW +: DW];
            end else begin
                exp_q.push_back('{due: cyc + LAT, port: g, data: m_mem[ga]});
            end
            if (bus_a.lock[g]) begin
                m_own_v = 1'b1;
                m_own   = g;
            end else begin
                m_own_v = 1'b0;
                m_ptr   = (g + 1) % N;
            end
        end else begin
            check_val("ram_we_idle", DW'(ram_we_a), '0);
            check_val("ram_re_idle", DW'(ram_re_a), '0);
        end
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Drive port p with a specific command, other slices random.
    task automatic acc_a(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [N-1:0] w, input int p,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [N*AW-1:0] aa;
        logic [N*DW-1:0] dd;
        aa = rand_addr();
        dd = rand_wdata();
        aa[p*AW +: AW] = a;
        dd[p*DW +: DW] = d;
        bus_a.req   = r;
        bus_a.lock  = l;
        bus_a.we    = w;
        bus_a.addr  = aa;
        bus_a.wdata = dd;
        step_a();
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) acc_a('0, '0, '0, 0, '0, '0);
    endtask

    task automatic step_b();
        logic [N-1:0] eg;
        @(negedge clk);
        eg = '0;
        for (int i = N-1; i >= 0; i--) if (bus_b.req[i]) eg = N'(1) << i;
        check_val("gnt_fixed", DW'(bus_b.gnt), DW'(eg));
        check_val("ram_we_fixed", DW'(ram_we_b), DW'((eg & bus_b.we) != '0));
        last_gnt_b = bus_b.gnt;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.req = '1; bus_a.lock = '0; bus_a.we = '0;
        bus_b.req = '1; bus_b.lock = '0; bus_b.we = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_gnt", DW'(bus_a.gnt), '0);
            check_val("rst_gnt_b", DW'(bus_b.gnt), '0);
            check_val("rst_rvalid", DW'(bus_a.rvalid), '0);
            check_val("rst_ram_cmd", DW'({ram_we_a, ram_re_a}), '0);
            check_val("rst_ptr", DW'(dbg_a.ptr), '0);
            check_val("rst_owner", DW'(dbg_a.owner_valid), '0);
            @(posedge clk);
            cyc++;
            #1;
        end
        exp_q.delete();
        m_ptr   = 0;
        m_own_v = 1'b0;
        m_own   = 0;
        bus_a.req = '0;
        bus_b.req = '0;
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        m_ptr = 0; m_own_v = 1'b0; m_own = 0;
        bus_a.req = '0; bus_a.lock = '0; bus_a.we = '0;
        bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = '0; bus_b.lock = '0; bus_b.we = '0;
        bus_b.addr = '0; bus_b.wdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Preload every RAM line through the arbiter.
        for (int a = 0; a < 16; a++) begin
            acc_a(N'(1) << (a % N), '0, N'(1) << (a % N), a % N, AW'(a),
                  {$urandom(), $urandom()});
        end

        // All four ports reading: strict rotation from pointer 0.
        for (int k = 0; k < 8; k++) begin
            acc_a('1, '0, '0, 0, AW'(k), '0);
            check_val("rr_order", DW'(last_gnt), DW'(N'(1) << (k % N)));
        end
        idle_a(LAT + 1);

        // Write from port 0 then read it back from port 3.
        acc_a(4'b0001, '0, 4'b0001, 0, 4'd7, 64'h0123_4567_89AB_CDEF);
        check_val("wr_we", DW'(last_we), 64'd1);
        acc_a(4'b1000, '0, '0, 3, 4'd7, '0);
        check_val("rd_re", DW'(last_re), 64'd1);
        idle_a(LAT + 1);

        // Port 1 read of addr 5 holding an A5 pattern.
        acc_a(4'b0001, '0, 4'b0001, 0, 4'd5, {8{8'hA5}});
        acc_a(4'b0010, '0, '0, 1, 4'd5, '0);
        idle_a(LAT + 1);

        // Lock burst on port 2; owner drops req mid-burst; release; port 3.
        acc_a(4'b0100, 4'b0100, '0, 2, 4'd1, '0);
        check_val("lock_1", DW'(last_gnt), 64'b0100);
        acc_a(4'b1111, 4'b0100, '0, 2, 4'd2, '0);
        check_val("lock_2", DW'(last_gnt), 64'b0100);
        acc_a(4'b1011, 4'b0100, '0, 2, 4'd3, '0);
        check_val("lock_stall", DW'(last_gnt), 64'b0000);
        acc_a(4'b1111, 4'b0000, '0, 2, 4'd4, '0);
        check_val("lock_release", DW'(last_gnt), 64'b0100);
        acc_a(4'b1011, '0, '0, 3, 4'd5, '0);
        check_val("after_lock", DW'(last_gnt), 64'b1000);
        idle_a(LAT + 1);

        // Read accepted, reset in the following cycle: the return is lost.
        acc_a(4'b0010, '0, '0, 1, 4'd9, '0);
        do_reset();
        idle_a(LAT + 3);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            bus_a.req   = N'($urandom_range(0, 15));
            bus_a.lock  = N'($urandom() & $urandom());
            bus_a.we    = N'($urandom());
            bus_a.addr  = rand_addr();
            bus_a.wdata = rand_wdata();
            step_a();
        end
        bus_a.lock = '0;
        // Let any remaining owner release, then drain returns.
        for (int i = 0; i < 4; i++) acc_a('1, '0, '0, 0, '0, '0);
        idle_a(LAT + 2);

        // Fixed priority instance.
        for (int i = 0; i < 4; i++) begin
            bus_b.req = 4'b1010;
            bus_b.we  = N'($urandom());
            step_b();
            check_val("fixed_1010", DW'(last_gnt_b), 64'b0010);
        end
        for (int i = 0; i < 40; i++) begin
            bus_b.req  = N'($urandom_range(0, 15));
            bus_b.we   = N'($urandom());
            bus_b.addr = rand_addr();
            step_b();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
